// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending session controller.
// Prices are in 5-unit steps; the credit width covers the worst-case overshoot.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  localparam int CREDIT_W   = 4;
  localparam int DEF_PRICE1 = 3;
  localparam int DEF_PRICE2 = 5;
  localparam int DEF_PRICE3 = 7;
  localparam int DEF_PRICE4 = 9;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Only called on a selection already known to be one-hot
  function automatic logic [CREDIT_W-1:0] price_of(
    input logic [3:0]          sel,
    input logic [CREDIT_W-1:0] p1,
    input logic [CREDIT_W-1:0] p2,
    input logic [CREDIT_W-1:0] p3,
    input logic [CREDIT_W-1:0] p4
  );
    logic [CREDIT_W-1:0] p;
    p = '0;
    unique case (1'b1)
      sel[0]:  p = p1;
      sel[1]:  p = p2;
      sel[2]:  p = p3;
      sel[3]:  p = p4;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle timer for the coin collection phase of a vending session.
// Built only when VEND_TIMEOUT_EN is defined.
module vend_timeout_timer
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  assign expire = (cnt == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vend_session_ctrl.sv
// Shared vending transaction sequencer: select, collect, dispense, change.
// Optional COLLECT idle auto-refund enabled by defining VEND_TIMEOUT_EN.
module vend_session_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE1         = DEF_PRICE1,
  parameter int PRICE2         = DEF_PRICE2,
  parameter int PRICE3         = DEF_PRICE3,
  parameter int PRICE4         = DEF_PRICE4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          item,
  input  logic                item_valid,
  input  logic                five_in,
  input  logic                ten_in,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                busy,
  output logic                disp_req,
  output logic [3:0]          disp_item,
  output logic                five_out,
  output logic                refund,
  output logic [CREDIT_W-1:0] credit,
  output logic                sel_err
);

  state_t              state;
  logic [3:0]          sel;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] chg;
  logic [CREDIT_W-1:0] sum;
  logic                coin;
  logic                expire;

  assign coin = five_in | ten_in;
  assign sum  = credit + {2'b00, ten_in, five_in};

`ifdef VEND_TIMEOUT_EN
  vend_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  ((state != S_COLLECT) || coin),
    .enable (state == S_COLLECT),
    .expire (expire)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      sel       <= '0;
      price     <= '0;
      chg       <= '0;
      busy      <= 1'b0;
      disp_req  <= 1'b0;
      disp_item <= '0;
      five_out  <= 1'b0;
      refund    <= 1'b0;
      credit    <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (item_valid) begin
            if (is_onehot(item)) begin
              sel   <= item;
              price <= price_of(item,
                                CREDIT_W'(PRICE1), CREDIT_W'(PRICE2),
                                CREDIT_W'(PRICE3), CREDIT_W'(PRICE4));
              busy  <= 1'b1;
              state <= S_COLLECT;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // A completed sale takes priority over a same-cycle abort
          if (sum >= price) begin
            chg       <= sum - price;
            credit    <= sum;
            disp_req  <= 1'b1;
            disp_item <= sel;
            state     <= S_DISPENSE;
          end else if (cancel || (expire && !coin)) begin
            if (sum == '0) begin
              credit <= '0;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end else begin
              chg      <= sum;
              credit   <= sum;
              refund   <= 1'b1;
              five_out <= 1'b1;
              state    <= S_REFUND;
            end
          end else begin
            credit <= sum;
          end
        end
        S_DISPENSE: begin
          if (disp_ack) begin
            disp_req  <= 1'b0;
            disp_item <= '0;
            credit    <= '0;
            if (chg != '0) begin
              five_out <= 1'b1;
              state    <= S_CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_CHANGE, S_REFUND: begin
          // chg counts the pulse currently on five_out
          if (chg > CREDIT_W'(1)) begin
            chg      <= chg - 1'b1;
            five_out <= 1'b1;
            if (state == S_REFUND) credit <= chg - 1'b1;
          end else begin
            chg      <= '0;
            five_out <= 1'b0;
            refund   <= 1'b0;
            credit   <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Vector-table bench for vend_session_ctrl with an expected-output queue.
// Timeout vectors follow VEND_TIMEOUT_EN with TIMEOUT_CYCLES=8.
module tb_vend_session_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] item;
  logic       item_valid;
  logic       five_in;
  logic       ten_in;
  logic       cancel;
  logic       disp_ack;
  logic       busy;
  logic       disp_req;
  logic [3:0] disp_item;
  logic       five_out;
  logic       refund;
  logic [3:0] credit;
  logic       sel_err;

  vend_session_ctrl #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .item       (item),
    .item_valid (item_valid),
    .five_in    (five_in),
    .ten_in     (ten_in),
    .cancel     (cancel),
    .disp_ack   (disp_ack),
    .busy       (busy),
    .disp_req   (disp_req),
    .disp_item  (disp_item),
    .five_out   (five_out),
    .refund     (refund),
    .credit     (credit),
    .sel_err    (sel_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] it;
    logic       iv;
    logic       f;
    logic       t;
    logic       c;
    logic       a;
    logic [12:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // {busy, disp_req, disp_item, five_out, refund, credit, sel_err}
  function automatic logic [12:0] o(input logic b, input logic r,
                                    input logic [3:0] di, input logic fo,
                                    input logic rf, input logic [3:0] cr,
                                    input logic se);
    return {b, r, di, fo, rf, cr, se};
  endfunction

  function automatic void add(input string n, input logic rst,
                              input logic [3:0] it, input logic iv,
                              input logic f, input logic t, input logic c,
                              input logic a, input logic [12:0] e);
    vec_t v;
    v.name = n; v.rst = rst; v.it = it; v.iv = iv;
    v.f = f; v.t = t; v.c = c; v.a = a; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic [12:0] act;
    logic [12:0] e;
    reset      = v.rst;
    item       = v.it;
    item_valid = v.iv;
    five_in    = v.f;
    ten_in     = v.t;
    cancel     = v.c;
    disp_ack   = v.a;
    sb.push_back(v.exp);
    @(posedge clock);
    #1;
    e   = sb.pop_front();
    act = {busy, disp_req, disp_item, five_out, refund, credit, sel_err};
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", v.name, act, e);
    end
  endtask

  logic [12:0] z;
  int          hold;

  initial begin
    z = o(0, 0, 4'h0, 0, 0, 4'd0, 0);
    // reset state
    add("rst0", 0, 4'h0, 0, 0, 0, 0, 0, z);
    add("rst1", 1, 4'h0, 0, 0, 0, 0, 0, z);
    // item 0001: ten, five, ack after 3 cycles
    add("a_sel",  1, 4'h1, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("a_ten",  1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("a_five", 1, 4'h0, 0, 1, 0, 0, 0, o(1, 1, 4'h1, 0, 0, 4'd3, 0));
    add("a_w1",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 1, 4'h1, 0, 0, 4'd3, 0));
    add("a_w2",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 1, 4'h1, 0, 0, 4'd3, 0));
    add("a_ack",  1, 4'h0, 0, 0, 0, 0, 1, z);
    add("a_ack2", 1, 4'h0, 0, 0, 0, 0, 1, z);
    // item 1000: 5 tens, one change coin
    add("b_sel",  1, 4'h8, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("b_t1",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("b_t2",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd4, 0));
    add("b_t3",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd6, 0));
    add("b_t4",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd8, 0));
    add("b_t5",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 1, 4'h8, 0, 0, 4'd10, 0));
    add("b_ack",  1, 4'h0, 0, 0, 0, 0, 1, o(1, 0, 4'h0, 1, 0, 4'd0, 0));
    add("b_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
    // item 0100: credit 3 then cancel
    add("c_sel",  1, 4'h4, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("c_ten",  1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("c_five", 1, 4'h0, 0, 1, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd3, 0));
    add("c_can",  1, 4'h0, 0, 0, 0, 1, 0, o(1, 0, 4'h0, 1, 1, 4'd3, 0));
    add("c_r2",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 1, 1, 4'd2, 0));
    add("c_r1",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 1, 1, 4'd1, 0));
    add("c_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
    // invalid selections
    add("d_two",  1, 4'h3, 1, 0, 0, 0, 0, o(0, 0, 4'h0, 0, 0, 4'd0, 1));
    add("d_zero", 1, 4'h0, 1, 0, 0, 0, 0, o(0, 0, 4'h0, 0, 0, 4'd0, 1));
    add("d_clr",  1, 4'h0, 0, 0, 0, 0, 0, z);
    add("d_coin", 1, 4'h0, 0, 1, 0, 0, 0, z);
    add("d_can",  1, 4'h0, 0, 0, 0, 1, 0, z);
    // item 0010: sale wins over cancel, selection locked
    add("e_sel",  1, 4'h2, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("e_t1",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("e_t2",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd4, 0));
    add("e_both", 1, 4'h0, 0, 1, 1, 1, 0, o(1, 1, 4'h2, 0, 0, 4'd7, 0));
    add("e_ign",  1, 4'h1, 1, 1, 0, 1, 0, o(1, 1, 4'h2, 0, 0, 4'd7, 0));
    add("e_ack",  1, 4'h0, 0, 0, 0, 0, 1, o(1, 0, 4'h0, 1, 0, 4'd0, 0));
    add("e_c2",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 1, 0, 4'd0, 0));
    add("e_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
    // cancel with zero credit, and cancel with same-cycle coin
    add("f_sel",  1, 4'h1, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("f_can",  1, 4'h0, 0, 0, 0, 1, 0, z);
    add("g_sel",  1, 4'h8, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("g_canc", 1, 4'h0, 0, 1, 0, 1, 0, o(1, 0, 4'h0, 1, 1, 4'd1, 0));
    add("g_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
    // reset mid-DISPENSE
    add("h_sel",  1, 4'h1, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("h_both", 1, 4'h0, 0, 1, 1, 0, 0, o(1, 1, 4'h1, 0, 0, 4'd3, 0));
    add("h_rst",  0, 4'h0, 0, 0, 0, 0, 0, z);
    add("h_idle", 1, 4'h0, 0, 0, 0, 0, 0, z);
    // selection locked: price stays 5 even after an item 0001 strobe
    add("i_sel",  1, 4'h2, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("i_ign",  1, 4'h1, 1, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("i_t2",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd4, 0));
    add("i_five", 1, 4'h0, 0, 1, 0, 0, 0, o(1, 1, 4'h2, 0, 0, 4'd5, 0));
    add("i_ack",  1, 4'h0, 0, 0, 0, 0, 1, z);
    // maximum credit 11 on item 1000
    add("j_sel",  1, 4'h8, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("j_t1",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("j_t2",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd4, 0));
    add("j_t3",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd6, 0));
    add("j_t4",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd8, 0));
    add("j_both", 1, 4'h0, 0, 1, 1, 0, 0, o(1, 1, 4'h8, 0, 0, 4'd11, 0));
    add("j_ack",  1, 4'h0, 0, 0, 0, 0, 1, o(1, 0, 4'h0, 1, 0, 4'd0, 0));
    add("j_c2",   1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 1, 0, 4'd0, 0));
    add("j_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
    // idle COLLECT: timeout refund or indefinite wait
    add("k_sel",  1, 4'h1, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("k_five", 1, 4'h0, 0, 1, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd1, 0));
    for (int i = 0; i < 7; i++)
      add("k_wait", 1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd1, 0));
`ifdef VEND_TIMEOUT_EN
    add("k_tout", 1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 1, 1, 4'd1, 0));
    add("k_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
`else
    for (int i = 0; i < 10; i++)
      add("k_hold", 1, 4'h0, 0, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd1, 0));
    add("k_can",  1, 4'h0, 0, 0, 0, 1, 0, o(1, 0, 4'h0, 1, 1, 4'd1, 0));
    add("k_end",  1, 4'h0, 0, 0, 0, 0, 0, z);
`endif

    foreach (vecs[i]) apply(vecs[i]);

    // disp_req holds for a random stall, ignoring coins and cancel
    vecs.delete();
    hold = $urandom_range(2, 6);
    add("m_sel",  1, 4'h4, 1, 0, 0, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd0, 0));
    add("m_t1",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd2, 0));
    add("m_t2",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd4, 0));
    add("m_t3",   1, 4'h0, 0, 0, 1, 0, 0, o(1, 0, 4'h0, 0, 0, 4'd6, 0));
    add("m_five", 1, 4'h0, 0, 1, 0, 0, 0, o(1, 1, 4'h4, 0, 0, 4'd7, 0));
    for (int i = 0; i < hold; i++)
      add("m_hold", 1, 4'h0, 0, i[0], 1, ~i[0], 0, o(1, 1, 4'h4, 0, 0, 4'd7, 0));
    add("m_ack",  1, 4'h0, 0, 0, 0, 0, 1, z);
    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
